// File: rtl/param_ram.sv
// Single-clock synchronous RAM with a valid/ready request port and per-bit write masks.
// It has a 1- or 2-stage read pipeline and an optional zero-fill sweep after reset.
module param_ram #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DEPTH          = 2**ADDR_WIDTH,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    input  logic [DATA_WIDTH-1:0] req_mask_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_error_o,
    output logic                  busy_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam state_e              RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  accept_s, in_range_s, wr_s, rd_s;
    logic                  s1_valid_q, s1_error_q;
    logic [DATA_WIDTH-1:0] s1_data_q;

    // Ready is gated by reset so nothing is accepted while rst_ni is low.
    assign req_ready_o = rst_ni && (state_q == ST_READY);
    assign busy_o      = (state_q == ST_CLEAR);
    assign accept_s    = req_valid_i && req_ready_o;
    assign in_range_s  = ({1'b0, req_addr_i} < DEPTH_W);
    assign wr_s        = accept_s && req_write_i && in_range_s;
    assign rd_s        = accept_s && !req_write_i;

    // Next state of the sweep controller: walk every word once, then serve requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = RESET_STATE;
        endcase
    end

    // Sweep controller registers; reset restarts the sweep from word 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage array has no reset: only the sweep and accepted writes modify it.
    always_ff @(posedge clk_i) begin
        if (rst_ni && (state_q == ST_CLEAR)) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_s) begin
            mem_q[req_addr_i] <= (mem_q[req_addr_i] & ~req_mask_i) | (req_data_i & req_mask_i);
        end
    end

    // First read stage samples the array at the accepting edge, after any earlier write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_error_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_s;
            if (rd_s) begin
                s1_data_q  <= in_range_s ? mem_q[req_addr_i] : '0;
                s1_error_q <= !in_range_s;
            end
        end
    end

    if (READ_LATENCY >= 2) begin : g_lat2
        logic                  s2_valid_q, s2_error_q;
        logic [DATA_WIDTH-1:0] s2_data_q;

        // Second stage forwards a response only when stage one holds one, so data is held between pulses.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
                s2_error_q <= 1'b0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q  <= s1_data_q;
                    s2_error_q <= s1_error_q;
                end
            end
        end

        assign rsp_valid_o = s2_valid_q;
        assign rsp_data_o  = s2_data_q;
        assign rsp_error_o = s2_error_q;
    end else begin : g_lat1
        assign rsp_valid_o = s1_valid_q;
        assign rsp_data_o  = s1_data_q;
        assign rsp_error_o = s1_error_q;
    end

endmodule

// File: tb/tb_param_ram.sv
// Directed bench for param_ram: three instances cover the sweep/latency-1 case,
// the latency-2 pipeline and a 200-word array with out-of-range addresses.
module tb_param_ram;

    logic       clk = 1'b0;
    logic       rst0_n, rst1_n, rst2_n;
    logic       valid0, valid1, valid2;
    logic       ready0, ready1, ready2;
    logic       req_write;
    logic [7:0] req_addr, req_data, req_mask;
    logic       rv0, rv1, rv2;
    logic [7:0] rd0, rd1, rd2;
    logic       re0, re1, re2;
    logic       busy0, busy1, busy2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    param_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u0 (
        .clk_i(clk), .rst_ni(rst0_n), .req_valid_i(valid0), .req_ready_o(ready0),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_data_i(req_data), .req_mask_i(req_mask),
        .rsp_valid_o(rv0), .rsp_data_o(rd0), .rsp_error_o(re0), .busy_o(busy0));

    param_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .READ_LATENCY(2), .CLEAR_ON_RESET(0)) u1 (
        .clk_i(clk), .rst_ni(rst1_n), .req_valid_i(valid1), .req_ready_o(ready1),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_data_i(req_data), .req_mask_i(req_mask),
        .rsp_valid_o(rv1), .rsp_data_o(rd1), .rsp_error_o(re1), .busy_o(busy1));

    param_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) u2 (
        .clk_i(clk), .rst_ni(rst2_n), .req_valid_i(valid2), .req_ready_o(ready2),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_data_i(req_data), .req_mask_i(req_mask),
        .rsp_valid_o(rv2), .rsp_data_o(rd2), .rsp_error_o(re2), .busy_o(busy2));

    typedef struct {
        int         inst;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] mask;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vt [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request to one instance: presented for a single accepting edge, sampled #1 later.
    task automatic op(input int inst, input logic wr, input logic [7:0] a, input logic [7:0] d, input logic [7:0] m);
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        req_mask  = m;
        valid0 = (inst == 0);
        valid1 = (inst == 1);
        valid2 = (inst == 2);
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        valid1 = 1'b0;
        valid2 = 1'b0;
    endtask

    task automatic count_sweep(output int n, output logic ready_bad);
        n = 0;
        ready_bad = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (busy0 && ready0) ready_bad = 1'b1;
        end while (busy0 && n < 1000);
    endtask

    initial begin
        int         n;
        logic       rbad;
        logic       v;
        logic [7:0] d;
        logic       e;
        logic       seen;

        vt[0]  = '{0, 1'b1, 8'h10, 8'hFF, 8'hFF, 8'h00, 1'b0};
        vt[1]  = '{0, 1'b1, 8'h10, 8'h00, 8'h0F, 8'h00, 1'b0};
        vt[2]  = '{0, 1'b0, 8'h10, 8'h00, 8'h00, 8'hF0, 1'b0};
        vt[3]  = '{0, 1'b1, 8'h05, 8'h3C, 8'hFF, 8'h00, 1'b0};
        vt[4]  = '{0, 1'b0, 8'h05, 8'h00, 8'h00, 8'h3C, 1'b0};
        vt[5]  = '{0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[6]  = '{0, 1'b0, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[7]  = '{0, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[8]  = '{0, 1'b1, 8'h20, 8'hA5, 8'hFF, 8'h00, 1'b0};
        vt[9]  = '{0, 1'b1, 8'h20, 8'h5A, 8'h3C, 8'h00, 1'b0};
        vt[10] = '{0, 1'b0, 8'h20, 8'h00, 8'h00, 8'h99, 1'b0};
        vt[11] = '{0, 1'b1, 8'h20, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[12] = '{0, 1'b0, 8'h20, 8'h00, 8'h00, 8'h99, 1'b0};
        vt[13] = '{2, 1'b1, 8'hC7, 8'h12, 8'hFF, 8'h00, 1'b0};
        vt[14] = '{2, 1'b1, 8'h00, 8'h34, 8'hFF, 8'h00, 1'b0};
        vt[15] = '{2, 1'b1, 8'h14, 8'h56, 8'hFF, 8'h00, 1'b0};
        vt[16] = '{2, 1'b1, 8'hDC, 8'h77, 8'hFF, 8'h00, 1'b0};
        vt[17] = '{2, 1'b0, 8'hDC, 8'h00, 8'h00, 8'h00, 1'b1};
        vt[18] = '{2, 1'b0, 8'hC7, 8'h00, 8'h00, 8'h12, 1'b0};
        vt[19] = '{2, 1'b0, 8'h00, 8'h00, 8'h00, 8'h34, 1'b0};
        vt[20] = '{2, 1'b0, 8'h14, 8'h00, 8'h00, 8'h56, 1'b0};
        vt[21] = '{2, 1'b0, 8'hC8, 8'h00, 8'h00, 8'h00, 1'b1};

        rst0_n = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0;
        valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
        req_write = 1'b0; req_addr = 8'h00; req_data = 8'h00; req_mask = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy0", {31'd0, busy0}, 32'd1);
        chk("reset_ready0", {31'd0, ready0}, 32'd0);
        chk("reset_rspvalid0", {31'd0, rv0}, 32'd0);
        chk("reset_rspdata0", {24'd0, rd0}, 32'd0);
        chk("reset_rsperr0", {31'd0, re0}, 32'd0);
        chk("reset_busy1", {31'd0, busy1}, 32'd0);
        chk("reset_ready1", {31'd0, ready1}, 32'd0);

        rst0_n = 1'b1; rst1_n = 1'b1; rst2_n = 1'b1;
        #1;
        chk("ready1_after_release", {31'd0, ready1}, 32'd1);
        count_sweep(n, rbad);
        chk("sweep1_edges", n, 32'd256);
        chk("sweep1_ready_low", {31'd0, rbad}, 32'd0);
        chk("ready0_after_sweep", {31'd0, ready0}, 32'd1);

        // Preload nonzero words, then a second reset must zero them again.
        op(0, 1'b1, 8'h00, 8'hA5, 8'hFF);
        op(0, 1'b1, 8'h80, 8'hA5, 8'hFF);
        op(0, 1'b1, 8'hFF, 8'hA5, 8'hFF);
        rst0_n = 1'b0;
        @(posedge clk);
        #1;
        rst0_n = 1'b1;
        count_sweep(n, rbad);
        chk("sweep2_edges", n, 32'd256);
        chk("sweep2_ready_low", {31'd0, rbad}, 32'd0);

        for (int i = 0; i < 22; i++) begin
            op(vt[i].inst, vt[i].wr, vt[i].addr, vt[i].data, vt[i].mask);
            if (vt[i].inst == 0) begin
                v = rv0; d = rd0; e = re0;
            end else begin
                v = rv2; d = rd2; e = re2;
            end
            chk($sformatf("vec%0d_valid", i), {31'd0, v}, {31'd0, !vt[i].wr});
            if (!vt[i].wr) begin
                chk($sformatf("vec%0d_data", i), {24'd0, d}, {24'd0, vt[i].exp_data});
                chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vt[i].exp_err});
            end
        end

        // Latency-2 pipeline: four back-to-back reads give four in-order pulses.
        for (int k = 1; k <= 4; k++) op(1, 1'b1, 8'(k), 8'(k * 8'h11), 8'hFF);
        for (int c = 0; c < 7; c++) begin
            req_write = 1'b0;
            req_addr  = 8'(c + 1);
            valid1    = (c < 4);
            @(posedge clk);
            #1;
            chk($sformatf("pipe%0d_valid", c), {31'd0, rv1}, (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
            if (c >= 1) chk($sformatf("pipe%0d_data", c), {24'd0, rd1}, (c <= 4) ? 32'(c * 8'h11) : 32'h44);
        end
        valid1 = 1'b0;

        // Read accepted, then reset before its response: nothing may come out.
        op(1, 1'b0, 8'h02, 8'h00, 8'h00);
        rst1_n = 1'b0;
        #1;
        seen = rv1;
        repeat (2) begin
            @(posedge clk);
            #1;
            seen = seen | rv1;
        end
        rst1_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen = seen | rv1;
        end
        chk("abort_no_rspvalid", {31'd0, seen}, 32'd0);
        chk("abort_rspdata_reset", {24'd0, rd1}, 32'd0);

        // Reset at sweep word 100 restarts a full sweep.
        rst0_n = 1'b0;
        @(posedge clk);
        #1;
        rst0_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("midsweep_busy", {31'd0, busy0}, 32'd1);
        rst0_n = 1'b0;
        #1;
        chk("midsweep_reset_ready", {31'd0, ready0}, 32'd0);
        @(posedge clk);
        #1;
        rst0_n = 1'b1;
        count_sweep(n, rbad);
        chk("sweep3_edges", n, 32'd256);
        chk("sweep3_ready_low", {31'd0, rbad}, 32'd0);
        op(0, 1'b0, 8'h20, 8'h00, 8'h00);
        chk("after_sweep3_data", {24'd0, rd0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
